// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and sizing for the memory responder
package mem_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_PROG = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - synchronous-write, combinational-read storage
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are deliberately not reset so a program survives a CPU reset.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - bus-side memory responder with programmer load FSM
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    input  logic              mem_write,
    input  logic              mem_read,
    output logic              rd_drive,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_byte,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count,
    output logic              busy,
    output logic              bus_error
);

    // Pointer value of the last storage location; a handshake here ends the session.
    localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     pointer_q, pointer_d;
    logic [ADDR_W:0]     prog_count_q, prog_count_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_drive_q, rd_drive_d;
    logic                bus_error_q, bus_error_d;
    logic                prog_mode_q;

    logic                prog_hs;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (Address),
        .rdata_o (mem_rdata)
    );

    // The bus is released the instant rd_drive_q clears, including on async reset.
    assign Data       = rd_drive_q ? rd_data_q : {DATA_W{1'bz}};
    assign rd_drive   = rd_drive_q;
    assign bus_error  = bus_error_q;
    assign prog_count = prog_count_q;

    // State register plus all datapath registers; prog_mode_q gives the 0->1 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pointer_q    <= '0;
            prog_count_q <= '0;
            rd_data_q    <= '0;
            rd_drive_q   <= 1'b0;
            bus_error_q  <= 1'b0;
            prog_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pointer_q    <= pointer_d;
            prog_count_q <= prog_count_d;
            rd_data_q    <= rd_data_d;
            rd_drive_q   <= rd_drive_d;
            bus_error_q  <= bus_error_d;
            prog_mode_q  <= prog_mode;
        end
    end

    // Next-state logic: prog_mode outranks bus strobes while idle.
    always_comb begin
        state_d      = state_q;
        pointer_d    = pointer_q;
        prog_count_d = prog_count_q;
        rd_data_d    = rd_data_q;
        rd_drive_d   = rd_drive_q;
        bus_error_d  = bus_error_q;
        case (state_q)
            ST_IDLE: begin
                rd_drive_d = 1'b0;
                if (prog_mode) begin
                    // A held prog_mode after a session parks here until it drops.
                    if (!prog_mode_q) begin
                        state_d   = ST_PROG;
                        pointer_d = '0;
                    end
                end else if (mem_read && mem_write) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_ERR;
                end else if (mem_read) begin
                    rd_data_d  = mem_rdata;
                    rd_drive_d = 1'b1;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_write) begin
                    bus_error_d = 1'b1;
                    rd_drive_d  = 1'b0;
                    state_d     = ST_ERR;
                end else if (mem_read) begin
                    rd_data_d = mem_rdata;
                end else begin
                    rd_drive_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_PROG: begin
                rd_drive_d = 1'b0;
                if (prog_hs) begin
                    pointer_d = pointer_q + 1'b1;
                end
                if ((prog_hs && (pointer_q == LAST_PTR)) || !prog_mode) begin
                    state_d      = ST_DONE;
                    prog_count_d = pointer_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                rd_drive_d  = 1'b0;
                bus_error_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and memory write steering decoded from the current state.
    always_comb begin
        prog_ready = (state_q == ST_PROG);
        prog_done  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        prog_hs    = prog_ready && prog_valid;
        mem_we     = prog_hs ||
                     ((state_q == ST_IDLE) && !prog_mode && mem_write && !mem_read);
        mem_waddr  = prog_ready ? pointer_q[ADDR_W-1:0] : Address;
        mem_wdata  = prog_ready ? prog_byte : Data;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Address;
    wire  [7:0]  Data;
    logic        mem_write;
    logic        mem_read;
    logic        rd_drive;
    logic        prog_mode;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_ready;
    logic        prog_done;
    logic [8:0]  prog_count;
    logic        busy;
    logic        bus_error;

    logic [7:0]  tb_data;
    logic        tb_drv;
    assign Data = tb_drv ? tb_data : 8'bz;

    mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Data       (Data),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .rd_drive   (rd_drive),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_byte  (prog_byte),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_count (prog_count),
        .busy       (busy),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    int         n_tests;
    int         n_fail;
    logic [7:0] ref_mem [256];
    logic [7:0] rd_exp [$];
    int         cnt_exp [$];
    int         done_seen;
    int         done_exp;
    logic [7:0] raq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rd_drive) begin
                    if (rd_exp.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rd_unexpected: Data=%0h driven with no read pending", Data);
                    end else begin
                        e = rd_exp.pop_front();
                        check("rd_data", {24'd0, Data}, {24'd0, e});
                    end
                end
                if (prog_done) begin
                    done_seen++;
                    if (cnt_exp.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL done_unexpected: prog_done with count %0d, none pending", prog_count);
                    end else begin
                        check("prog_count", {23'd0, prog_count}, cnt_exp.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        Address   = a;
        tb_data   = d;
        tb_drv    = 1'b1;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        tb_drv    = 1'b0;
        ref_mem[a] = d;
    endtask

    // One read sample per address in raq, each one cycle after the previous.
    task automatic read_seq();
        foreach (raq[i]) begin
            Address  = raq[i];
            mem_read = 1'b1;
            rd_exp.push_back(ref_mem[raq[i]]);
            tick();
        end
        mem_read = 1'b0;
        tick();
        check("rd_release", {31'd0, rd_drive}, 32'd0);
    endtask

    task automatic prog_send(input logic [7:0] d, input int ptr);
        for (int k = 0; k < 4 && !prog_ready; k++) tick();
        check("prog_ready_wait", {31'd0, prog_ready}, 32'd1);
        prog_valid = 1'b1;
        prog_byte  = d;
        ref_mem[ptr] = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; prog_mode = 1'b0; prog_valid = 1'b0; tb_drv = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] b;
        n_tests = 0; n_fail = 0; done_seen = 0; done_exp = 0;
        reset = 1'b1; Address = '0; mem_write = 1'b0; mem_read = 1'b0;
        prog_mode = 1'b0; prog_valid = 1'b0; prog_byte = '0; tb_data = '0; tb_drv = 1'b0;
        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        tick();
        tick();
        check("rst_rd_drive",   {31'd0, rd_drive},   32'd0);
        check("rst_prog_ready", {31'd0, prog_ready}, 32'd0);
        check("rst_prog_done",  {31'd0, prog_done},  32'd0);
        check("rst_prog_count", {23'd0, prog_count}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_bus_error",  {31'd0, bus_error},  32'd0);
        reset = 1'b0;
        tick();

        // Gapped three-byte programming session ended by dropping prog_mode.
        prog_mode = 1'b1;
        tick();
        check("sess_ready", {31'd0, prog_ready}, 32'd1);
        check("sess_busy",  {31'd0, busy},       32'd1);
        prog_send(8'h11, 0); tick();
        prog_send(8'h22, 1); tick();
        prog_send(8'h33, 2);
        cnt_exp.push_back(3); done_exp++;
        prog_mode = 1'b0;
        tick();
        tick();
        check("sess_idle", {31'd0, busy}, 32'd0);

        // Bus write then a read burst that steps Address.
        bus_write(8'h10, 8'hA5);
        raq.delete(); raq.push_back(8'h10); raq.push_back(8'h00);
        read_seq();

        // Full-depth load with extra valid bytes after the last address.
        prog_mode = 1'b1;
        tick();
        cnt_exp.push_back(256); done_exp++;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            prog_valid = 1'b1;
            prog_byte  = b;
            ref_mem[i] = b;
            tick();
        end
        check("full_ready_drop", {31'd0, prog_ready}, 32'd0);
        prog_byte = 8'hEE;
        tick(); tick(); tick();
        check("full_no_restart_ready", {31'd0, prog_ready}, 32'd0);
        check("full_no_restart_busy",  {31'd0, busy},       32'd0);
        check("full_count_hold", {23'd0, prog_count}, 32'd256);
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        tick();
        raq.delete(); raq.push_back(8'h00); raq.push_back(8'hFF); raq.push_back(8'h80);
        read_seq();

        // Reset in the middle of a programming session.
        prog_mode = 1'b1;
        tick();
        prog_send(8'hC1, 0);
        prog_send(8'hC2, 1);
        reset = 1'b1;
        #1;
        check("prst_count", {23'd0, prog_count}, 32'd0);
        check("prst_busy",  {31'd0, busy},       32'd0);
        check("prst_ready", {31'd0, prog_ready}, 32'd0);
        prog_mode = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        raq.delete(); raq.push_back(8'h00); raq.push_back(8'h01);
        read_seq();

        // prog_mode and mem_write together: programming wins, no bus write.
        Address   = 8'h20;
        tb_data   = ~ref_mem[8'h20];
        tb_drv    = 1'b1;
        mem_write = 1'b1;
        prog_mode = 1'b1;
        tick();
        mem_write = 1'b0;
        tb_drv    = 1'b0;
        check("prio_ready", {31'd0, prog_ready}, 32'd1);
        cnt_exp.push_back(0); done_exp++;
        prog_mode = 1'b0;
        tick();
        tick();
        raq.delete(); raq.push_back(8'h20);
        read_seq();

        // Randomized mix of bus writes and read bursts against the model.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus_write(8'($urandom), 8'($urandom));
            end else begin
                raq.delete();
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) raq.push_back(8'($urandom));
                read_seq();
            end
        end

        // Write strobe arriving during a read burst.
        Address  = 8'h30;
        mem_read = 1'b1;
        rd_exp.push_back(ref_mem[8'h30]);
        tick();
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        check("rdwr_err",   {31'd0, bus_error}, 32'd1);
        check("rdwr_drive", {31'd0, rd_drive},  32'd0);
        pulse_reset();
        check("rdwr_clear", {31'd0, bus_error}, 32'd0);

        // Simultaneous read and write strobes from idle.
        bus_write(8'h10, 8'hA5);
        Address   = 8'h10;
        tb_data   = 8'h5A;
        tb_drv    = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        tb_drv    = 1'b0;
        tick();
        check("conf_err",   {31'd0, bus_error}, 32'd1);
        check("conf_drive", {31'd0, rd_drive},  32'd0);
        check("conf_busy",  {31'd0, busy},      32'd1);
        mem_read = 1'b0;
        bus_write(8'h10, 8'h77);
        ref_mem[8'h10] = 8'hA5;
        tick();
        check("conf_sticky", {31'd0, bus_error}, 32'd1);
        pulse_reset();
        check("conf_clear", {31'd0, bus_error}, 32'd0);
        raq.delete(); raq.push_back(8'h10);
        read_seq();

        // Asynchronous release of the bus on reset during a read.
        Address  = 8'h05;
        mem_read = 1'b1;
        rd_exp.push_back(ref_mem[8'h05]);
        tick();
        check("mrd_drive", {31'd0, rd_drive}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mrd_release", {31'd0, rd_drive}, 32'd0);
        mem_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("mrd_busy", {31'd0, busy}, 32'd0);

        tick(); tick();
        check("rd_queue_empty",  rd_exp.size(),  32'd0);
        check("cnt_queue_empty", cnt_exp.size(), 32'd0);
        check("done_pulses",     done_seen,      done_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
